// File: rtl/RV32i_pkg.sv
// RV32i_pkg: ALU function encodings and sequencer states shared by alu_seq and muldiv_iter
package RV32i_pkg;
  typedef enum logic [4:0] {
    ALU_ADD      = 5'd0,
    ALU_SUB      = 5'd1,
    ALU_AND      = 5'd2,
    ALU_OR       = 5'd3,
    ALU_XOR      = 5'd4,
    ALU_SLT      = 5'd5,
    ALU_SLTU     = 5'd6,
    ALU_SLL      = 5'd7,
    ALU_SRL      = 5'd8,
    ALU_SRA      = 5'd9,
    ALU_COPY_RS1 = 5'd10,
    ALU_MUL      = 5'd16,
    ALU_MULH     = 5'd17,
    ALU_MULHSU   = 5'd18,
    ALU_MULHU    = 5'd19,
    ALU_DIV      = 5'd20,
    ALU_DIVU     = 5'd21,
    ALU_REM      = 5'd22,
    ALU_REMU     = 5'd23
  } alu_func_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_t;
  function automatic logic is_mul(alu_func_t f);
    return f[4:2] == 3'b100;
  endfunction
  function automatic logic is_div(alu_func_t f);
    return f[4:2] == 3'b101;
  endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle shift-add multiplier and restoring divider on magnitudes with final sign fix-up;
// the divider path exists only when ALU_SEQ_DIV_EN is defined
module muldiv_iter
  import RV32i_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  alu_func_t        func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);
  logic busy, s1, s2, n1, n2, dv, neg_x, sel_hi;
  logic [SHAMT_W:0] cnt;
  logic [WIDTH-1:0] hi, lo, m, nhi, nlo, ma, mb;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] prod;
  assign s1 = func inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
  assign s2 = func inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
  assign n1 = s1 && a[WIDTH-1];
  assign n2 = s2 && b[WIDTH-1];
  assign ma = n1 ? -a : a;
  assign mb = n2 ? -b : b;
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
  assign prod = neg_x ? -{nhi, nlo} : {nhi, nlo};
  assign done = busy && cnt == '0;
`ifdef ALU_SEQ_DIV_EN
  logic is_d, neg_r, ok;
  logic [WIDTH+1:0] t;
  assign dv = is_div(func);
  assign t = {1'b0, hi, lo[WIDTH-1]} - {2'b00, m};
  assign ok = t[WIDTH+1:WIDTH] == 2'b00;
  assign nhi = is_d ? (ok ? t[WIDTH-1:0] : {hi[WIDTH-2:0], lo[WIDTH-1]}) : sum[WIDTH:1];
  assign nlo = is_d ? {lo[WIDTH-2:0], ok} : {sum[0], lo[WIDTH-1:1]};
  assign res = is_d ? (sel_hi ? (neg_r ? -nhi : nhi) : (neg_x ? -nlo : nlo))
                    : (sel_hi ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0]);
`else
  assign dv = 1'b0;
  assign nhi = sum[WIDTH:1];
  assign nlo = {sum[0], lo[WIDTH-1:1]};
  assign res = sel_hi ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
`endif
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      busy <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= (SHAMT_W+1)'(WIDTH-1);
    end else if (busy) begin
      busy <= !done;
      cnt <= done ? cnt : cnt - (SHAMT_W+1)'(1);
    end
  end
  // Multiply keeps the multiplier in lo; divide keeps the dividend there and shifts quotient bits in
  always_ff @(posedge clk) begin
    if (start) begin
      hi <= '0;
      lo <= dv ? ma : mb;
      m <= dv ? mb : ma;
      neg_x <= n1 ^ n2;
      sel_hi <= func inside {ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_REM, ALU_REMU};
`ifdef ALU_SEQ_DIV_EN
      is_d <= dv;
      neg_r <= n1;
`endif
    end else if (busy) begin
      hi <= nhi;
      lo <= nlo;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle RV32IM ALU behind a valid/ready handshake with registered result and flags;
// define ALU_SEQ_DIV_EN to build the divider, otherwise DIV/DIVU/REM/REMU return 0 in one cycle
module alu_seq
  import RV32i_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  alu_func_t        func_i,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] d_o,
  output logic             zero_o,
  output logic             lt_o,
  output logic             ltu_o
);
  alu_state_t state, state_n;
  logic accept, iter, md_done, lt, ltu, lt_p, ltu_p;
  logic [WIDTH-1:0] simple, md_res;
  logic [SHAMT_W-1:0] sh;
  assign accept = valid_i && ready_o;
  assign lt = $signed(op1_i) < $signed(op2_i);
  assign ltu = op1_i < op2_i;
  assign sh = op2_i[SHAMT_W-1:0];
`ifdef ALU_SEQ_DIV_EN
  logic div_zero, div_ovf;
  assign div_zero = op2_i == '0;
  assign div_ovf = func_i inside {ALU_DIV, ALU_REM} && op1_i == {1'b1, {(WIDTH-1){1'b0}}} && op2_i == '1;
  assign iter = is_mul(func_i) || (is_div(func_i) && !div_zero && !div_ovf);
`else
  assign iter = is_mul(func_i);
`endif
  always_comb begin
    simple = '0;
    case (func_i)
      ALU_ADD:      simple = op1_i + op2_i;
      ALU_SUB:      simple = op1_i - op2_i;
      ALU_AND:      simple = op1_i & op2_i;
      ALU_OR:       simple = op1_i | op2_i;
      ALU_XOR:      simple = op1_i ^ op2_i;
      ALU_SLT:      simple = {{(WIDTH-1){1'b0}}, lt};
      ALU_SLTU:     simple = {{(WIDTH-1){1'b0}}, ltu};
      ALU_SLL:      simple = op1_i << sh;
      ALU_SRL:      simple = op1_i >> sh;
      ALU_SRA:      simple = $signed(op1_i) >>> sh;
      ALU_COPY_RS1: simple = op1_i;
`ifdef ALU_SEQ_DIV_EN
      // Only divide-by-zero and signed overflow reach here; the rest go to the iterator
      ALU_DIV, ALU_DIVU: simple = div_zero ? '1 : op1_i;
      ALU_REM, ALU_REMU: simple = div_zero ? op1_i : '0;
`endif
      default:      simple = '0;
    endcase
  end
  muldiv_iter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_md (
    .clk(clk_i),
    .rst(rst_i),
    .start(accept && iter),
    .kill(kill_i && state == BUSY),
    .func(func_i),
    .a(op1_i),
    .b(op2_i),
    .done(md_done),
    .res(md_res)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (iter ? BUSY : DONE) : IDLE;
      BUSY:    state_n = kill_i ? IDLE : (md_done ? DONE : BUSY);
      DONE:    state_n = (kill_i || ready_i) ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    ready_o = state == IDLE;
    valid_o = state == DONE;
  end
  // Flags of an iterative op are parked in lt_p/ltu_p so they appear together with d_o
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_o <= '0;
      zero_o <= 1'b0;
      lt_o <= 1'b0;
      ltu_o <= 1'b0;
      lt_p <= 1'b0;
      ltu_p <= 1'b0;
    end else if (accept) begin
      lt_p <= lt;
      ltu_p <= ltu;
      if (!iter) begin
        d_o <= simple;
        zero_o <= simple == '0;
        lt_o <= lt;
        ltu_o <= ltu;
      end
    end else if (md_done && !kill_i) begin
      d_o <= md_res;
      zero_o <= md_res == '0;
      lt_o <= lt_p;
      ltu_o <= ltu_p;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven directed vectors plus hand-written backpressure, kill and reset sequences for alu_seq
module tb_alu_seq;
  import RV32i_pkg::*;
  logic clk_i = 1'b0, rst_i = 1'b1, valid_i = 1'b0, kill_i = 1'b0, ready_i = 1'b0;
  alu_func_t func_i = ALU_ADD;
  logic [31:0] op1_i = '0, op2_i = '0, d_o;
  logic ready_o, valid_o, zero_o, lt_o, ltu_o;
  int checks = 0, passed = 0;
`ifdef ALU_SEQ_DIV_EN
  localparam bit DE = 1'b1;
`else
  localparam bit DE = 1'b0;
`endif
  localparam int NV = 29;
  typedef struct {
    alu_func_t f;
    logic [31:0] a, b, d;
    int lat;
    logic z, lt, ltu;
  } vec_t;
  vec_t v[NV];
  always #5 clk_i = ~clk_i;
  alu_seq #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .func_i(func_i),
    .op1_i(op1_i), .op2_i(op2_i), .kill_i(kill_i), .valid_o(valid_o), .ready_i(ready_i),
    .d_o(d_o), .zero_o(zero_o), .lt_o(lt_o), .ltu_o(ltu_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask
  task automatic issue(input alu_func_t f, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk_i);
    valid_i = 1'b1; func_i = f; op1_i = a; op2_i = b;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
  endtask
  task automatic retire();
    @(negedge clk_i); ready_i = 1'b1;
    @(posedge clk_i); #1; ready_i = 1'b0;
  endtask
  task automatic no_valid(input string name, input int n);
    int seen = 0;
    repeat (n) begin
      @(posedge clk_i); #1;
      seen += int'(valid_o);
    end
    chk(name, 32'(seen), 32'd0);
  endtask
  initial begin
    int lat;
    string n;
    v[0]  = '{ALU_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 1'b0, 1'b0, 1'b0};
    v[1]  = '{ALU_SUB, 32'h5, 32'h7, 32'hFFFFFFFE, 1, 1'b0, 1'b1, 1'b1};
    v[2]  = '{ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1, 1'b0, 1'b1, 1'b0};
    v[3]  = '{ALU_OR, 32'h0, 32'h0, 32'h0, 1, 1'b1, 1'b0, 1'b0};
    v[4]  = '{ALU_XOR, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 1, 1'b0, 1'b1, 1'b0};
    v[5]  = '{ALU_SLT, 32'hFFFFFFFF, 32'h1, 32'h1, 1, 1'b0, 1'b1, 1'b0};
    v[6]  = '{ALU_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 1'b1, 1'b1, 1'b0};
    v[7]  = '{ALU_SLL, 32'h1, 32'd31, 32'h80000000, 1, 1'b0, 1'b1, 1'b1};
    v[8]  = '{ALU_SRL, 32'h80000000, 32'd4, 32'h08000000, 1, 1'b0, 1'b1, 1'b0};
    v[9]  = '{ALU_SRA, 32'h80000000, 32'd33, 32'hC0000000, 1, 1'b0, 1'b1, 1'b0};
    v[10] = '{ALU_COPY_RS1, 32'h12345678, 32'h0, 32'h12345678, 1, 1'b0, 1'b0, 1'b0};
    v[11] = '{alu_func_t'(5'd11), 32'h5, 32'h3, 32'h0, 1, 1'b1, 1'b0, 1'b0};
    v[12] = '{ALU_MULH, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 33, 1'b0, 1'b1, 1'b0};
    v[13] = '{ALU_MUL, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFA, 33, 1'b0, 1'b1, 1'b0};
    v[14] = '{ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0, 1'b0, 1'b0};
    v[15] = '{ALU_MULHSU, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 33, 1'b0, 1'b1, 1'b0};
    v[16] = '{ALU_MUL, 32'h0, 32'h5, 32'h0, 33, 1'b1, 1'b1, 1'b1};
    v[17] = '{ALU_MULHU, 32'h80000000, 32'h4, 32'h2, 33, 1'b0, 1'b1, 1'b0};
    v[18] = '{ALU_DIV, 32'hFFFFFFF9, 32'h2, DE ? 32'hFFFFFFFD : 32'h0, DE ? 33 : 1, ~DE, 1'b1, 1'b0};
    v[19] = '{ALU_REM, 32'hFFFFFFF9, 32'h2, DE ? 32'hFFFFFFFF : 32'h0, DE ? 33 : 1, ~DE, 1'b1, 1'b0};
    v[20] = '{ALU_DIVU, 32'h4D2, 32'h0, DE ? 32'hFFFFFFFF : 32'h0, 1, ~DE, 1'b0, 1'b0};
    v[21] = '{ALU_REMU, 32'h4D2, 32'h0, DE ? 32'h4D2 : 32'h0, 1, ~DE, 1'b0, 1'b0};
    v[22] = '{ALU_DIV, 32'h80000000, 32'hFFFFFFFF, DE ? 32'h80000000 : 32'h0, 1, ~DE, 1'b1, 1'b1};
    v[23] = '{ALU_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 1'b1, 1'b1, 1'b1};
    v[24] = '{ALU_DIVU, 32'd100, 32'd7, DE ? 32'd14 : 32'h0, DE ? 33 : 1, ~DE, 1'b0, 1'b0};
    v[25] = '{ALU_REMU, 32'd100, 32'd7, DE ? 32'd2 : 32'h0, DE ? 33 : 1, ~DE, 1'b0, 1'b0};
    v[26] = '{ALU_DIV, 32'h7, 32'hFFFFFFFE, DE ? 32'hFFFFFFFD : 32'h0, DE ? 33 : 1, ~DE, 1'b0, 1'b1};
    v[27] = '{ALU_REM, 32'h7, 32'hFFFFFFFE, DE ? 32'h1 : 32'h0, DE ? 33 : 1, ~DE, 1'b0, 1'b1};
    v[28] = '{ALU_REM, 32'hFFFFFFF9, 32'hFFFFFFFE, DE ? 32'hFFFFFFFF : 32'h0, DE ? 33 : 1, ~DE, 1'b1, 1'b1};
    repeat (3) @(posedge clk_i);
    #1;
    chk1("reset ready", ready_o, 1'b1);
    chk1("reset valid", valid_o, 1'b0);
    chk("reset d", d_o, 32'h0);
    chk1("reset zero", zero_o, 1'b0);
    chk1("reset lt", lt_o, 1'b0);
    chk1("reset ltu", ltu_o, 1'b0);
    @(negedge clk_i); rst_i = 1'b0;
    for (int i = 0; i < NV; i++) begin
      n = $sformatf("v%0d", i);
      issue(v[i].f, v[i].a, v[i].b, lat);
      chk({n, " lat"}, 32'(lat), 32'(v[i].lat));
      chk({n, " d"}, d_o, v[i].d);
      chk1({n, " zero"}, zero_o, v[i].z);
      chk1({n, " lt"}, lt_o, v[i].lt);
      chk1({n, " ltu"}, ltu_o, v[i].ltu);
      chk1({n, " ready in done"}, ready_o, 1'b0);
      retire();
      chk1({n, " ready after"}, ready_o, 1'b1);
    end
    issue(ALU_SUB, 32'h3, 32'h5, lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      valid_i = 1'b1; func_i = ALU_ADD; op1_i = 32'(k); op2_i = 32'h1;
      @(posedge clk_i); #1;
      chk("bp d", d_o, 32'hFFFFFFFE);
      chk1("bp valid", valid_o, 1'b1);
      chk1("bp ready", ready_o, 1'b0);
      chk1("bp zero", zero_o, 1'b0);
      chk1("bp lt", lt_o, 1'b1);
      chk1("bp ltu", ltu_o, 1'b1);
    end
    @(negedge clk_i); ready_i = 1'b1;
    @(posedge clk_i); #1; ready_i = 1'b0; valid_i = 1'b0;
    chk1("bp no accept valid", valid_o, 1'b0);
    chk1("bp no accept ready", ready_o, 1'b1);
    @(negedge clk_i);
    valid_i = 1'b1; func_i = ALU_MUL; op1_i = 32'h3; op2_i = 32'h4;
    @(posedge clk_i); #1; valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    chk1("busy ready", ready_o, 1'b0);
    chk1("busy valid", valid_o, 1'b0);
    @(negedge clk_i); kill_i = 1'b1;
    @(posedge clk_i); #1; kill_i = 1'b0;
    chk1("kill busy valid", valid_o, 1'b0);
    chk1("kill busy ready", ready_o, 1'b1);
    no_valid("kill busy dropped", 40);
    issue(ALU_ADD, 32'h2, 32'h3, lat);
    chk("post kill lat", 32'(lat), 32'd1);
    chk("post kill d", d_o, 32'h5);
    @(negedge clk_i); kill_i = 1'b1;
    @(posedge clk_i); #1; kill_i = 1'b0;
    chk1("kill done valid", valid_o, 1'b0);
    chk1("kill done ready", ready_o, 1'b1);
    @(negedge clk_i);
    valid_i = 1'b1; kill_i = 1'b1; func_i = ALU_SUB; op1_i = 32'h3; op2_i = 32'h4;
    @(posedge clk_i); #1; valid_i = 1'b0; kill_i = 1'b0;
    chk1("kill idle valid", valid_o, 1'b1);
    chk("kill idle d", d_o, 32'hFFFFFFFF);
    retire();
    @(negedge clk_i);
    valid_i = 1'b1; func_i = ALU_MULHU; op1_i = 32'hFFFFFFFF; op2_i = 32'hFFFFFFFF;
    @(posedge clk_i); #1; valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1; rst_i = 1'b0;
    chk1("rst busy valid", valid_o, 1'b0);
    chk1("rst busy ready", ready_o, 1'b1);
    chk("rst busy d", d_o, 32'h0);
    chk1("rst busy lt", lt_o, 1'b0);
    chk1("rst busy ltu", ltu_o, 1'b0);
    no_valid("rst busy dropped", 40);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
